// File: rtl/fetch_queue.sv
// Show-ahead instruction buffer between fetch and decode. Holds {Instr, PC, PC+4}
// triples, presents the oldest to decode and back-pressures fetch when full.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ValidF,
  input  logic [31:0]              InstrF,
  input  logic [31:0]              PCF,
  input  logic [31:0]              PCPlus4F,
  input  logic                     FlushE,
  input  logic                     StallD,
  output logic                     FullF,
  output logic                     ValidD,
  output logic [31:0]              InstrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus4D,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [95:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [95:0]   w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A flush cycle's fetch is wrong-path, so it never reaches storage.
  assign w_push = ValidF & ~w_full & ~FlushE;
  assign w_pop  = ~w_empty & ~StallD;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {InstrF, PCF, PCPlus4F};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  // Empty queue presents a bubble so decode sees a harmless NOP.
  assign FullF    = w_full;
  assign ValidD   = ~w_empty;
  assign InstrD   = w_empty ? NOP   : w_head[95:64];
  assign PCD      = w_empty ? 32'h0 : w_head[63:32];
  assign PCPlus4D = w_empty ? 32'h0 : w_head[31:0];
  assign CountQ   = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: a queue-based model tracks accepted
// fetches and a negedge monitor compares every visible output against it.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FlushE;
  logic        StallD;
  logic        FullF;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [2:0]  CountQ;

  int checks = 0;
  int errors = 0;
  bit monEn  = 1'b0;

  logic [95:0] expQ[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP(32'h00000013)) dut (
    .clk(clk), .rst(rst), .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .FlushE(FlushE), .StallD(StallD), .FullF(FullF),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .CountQ(CountQ)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted fetches, updated from the inputs at each edge.
  always @(posedge clk) begin
    if (rst || FlushE) begin
      expQ.delete();
    end else begin
      int sizeBefore;
      sizeBefore = expQ.size();
      if (sizeBefore != 0 && !StallD) void'(expQ.pop_front());
      if (ValidF && sizeBefore != DEPTH) expQ.push_back({InstrF, PCF, PCPlus4F});
    end
  end

  // Monitor: mid-cycle compare of every output against the model's current contents.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("CountQ", 32'(CountQ), 32'(expQ.size()));
      checkOutput("ValidD", 32'(ValidD), 32'(expQ.size() != 0));
      checkOutput("FullF",  32'(FullF),  32'(expQ.size() == DEPTH));
      if (expQ.size() != 0) begin
        checkOutput("InstrD",   InstrD,   expQ[0][95:64]);
        checkOutput("PCD",      PCD,      expQ[0][63:32]);
        checkOutput("PCPlus4D", PCPlus4D, expQ[0][31:0]);
      end else begin
        checkOutput("InstrD_empty",   InstrD,   32'h00000013);
        checkOutput("PCD_empty",      PCD,      32'h0);
        checkOutput("PCPlus4D_empty", PCPlus4D, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic s,
                               input logic f, input logic r);
    ValidF   = v;
    InstrF   = $urandom;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    StallD   = s;
    FlushE   = f;
    rst      = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] pcCnt;
    $display("[TB] start");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    monEn = 1'b1;
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);

    // Fill under stall, drop the fifth, then drain in order.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'(k * 4), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Streaming: push and pop every cycle.
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 32'h100 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Three entries then a flush carrying a wrong-path fetch.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h180 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Pointer wrap with toggling stall.
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 32'h300 + 32'(k * 4), 1'(k % 2), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous pop and rejected push, then reset mid-fill.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h400 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h410, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 32'h500 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h508, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    pcCnt = 32'h1000;
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), pcCnt, 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 60) == 0));
      pcCnt = pcCnt + 32'd4;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
